seg_display_arbiter: RTL and testbench
======================================

Name: seg_display_arbiter

Overview:
- Shares the single quad_seven_seg display between two requesters: requester 0 is the normal status/counter source, requester 1 is the alert source.
- Grants ownership using a request/grant handshake and drives val3..val0 of quad_seven_seg from the current owner's 16-bit word.
- Enforces a minimum dwell time so the display cannot thrash between sources faster than a human can read it.

Parameters:
- HOLD_CYCLES, 1000000, minimum ownership cycles before preemption (10 ms at 100 MHz); legal range ≥1.
- CNT_W, 20, dwell counter width; must satisfy 2^CNT_W ≥ HOLD_CYCLES.
- IDLE_VAL, 16'h0000, word shown when no one owns the display.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous active-high reset.
- req0  input  1  requester 0 wants the display (level, held while wanted).
- data0  input  16  requester 0 word: [15:12]→val3 … [3:0]→val0.
- req1  input  1  requester 1 (alert) wants the display.
- data1  input  16  requester 1 word, same packing.
- gnt0  output  1  requester 0 owns the display (registered).
- gnt1  output  1  requester 1 owns the display (registered).
- val3, val2, val1, val0  output  4 each  nibbles to quad_seven_seg (registered).
- dwell_done  output  1  current owner has met HOLD_CYCLES.

Behaviour:
- Clock and reset: one clock domain, clk. rst is asynchronous, active-high and clears every output immediately, including mid-ownership.
  - gnt0 = gnt1 = 0, dwell_done = 0.
  - val3..val0 = IDLE_VAL nibbles.
  - State = IDLE, dwell count = 0.
- States: IDLE, OWN0, OWN1. gnt0 and gnt1 are one-hot decodes of OWN0/OWN1 and are never both 1.
- IDLE:
  - req1 → OWN1; else req0 → OWN0; else stay.
  - Grant is asserted on the edge after the request is sampled (1-cycle latency).
  - On that same edge, val is loaded from the new owner's data.
- Entering any OWN state: dwell count ← 0 and dwell_done ← 0. Count increments every cycle in the state and saturates; dwell_done = 1 once count reaches HOLD_CYCLES-1.
- While OWNx and reqx = 1: val ← datax on every edge, so display updates lag data by 1 cycle. The non-owner's data is ignored.
- Release: OWNx with reqx = 0:
  - If the other request is high → direct handover to the other OWN state on the same edge, with no IDLE cycle and val ← other data.
  - Else → IDLE, with val ← IDLE_VAL.
- Preemption: OWN0 with req0 = 1, req1 = 1 and dwell_done = 1 → OWN1 on the next edge. Before dwell_done, req1 waits with gnt1 = 0.
- OWN1 is never preempted by req0 (fixed priority); req0 waits until req1 drops.
- Simultaneous events:
  - Both requests high in IDLE → OWN1.
  - Owner drop plus other request in the same cycle → handover, not IDLE.
- HOLD_CYCLES = 1: dwell_done rises one cycle after entry, so preemption occurs 2 cycles after the grant at the earliest.
- The dwell count never wraps; it saturates at HOLD_CYCLES-1 until the next state entry.

Optional Feature:
- Macro: SEG_ARB_ROUND_ROBIN_EN.
- Defined:
  - OWN1 is also preempted by req0 once dwell_done = 1.
  - Both requests high in IDLE → grant the requester that did not own last. A last-owner flop is cleared to 0 by reset, so requester 1 wins first.
- Undefined: fixed priority exactly as in Behaviour; no last-owner flop is synthesized.

Decomposition:
- Package seg_arb_pkg:
  - state enum {IDLE, OWN0, OWN1}.
  - Default IDLE_VAL constant.
  - Function splitting a 16-bit word into four nibbles.
- Sub-module seg_dwell_timer: CNT_W saturating counter with synchronous clear input, async rst, and done output compared against HOLD_CYCLES-1. Instantiated once.
- Arbiter FSM and val registers live in seg_display_arbiter.

Test Plan (HOLD_CYCLES = 8, IDLE_VAL = 16'h0000):
- Reset then idle: rst pulse with no requests → gnt0 = gnt1 = 0, val3..val0 = 0,0,0,0 held indefinitely.
- Single owner: req0 = 1, data0 = 16'h0123 → gnt0 = 1 and val = 0,1,2,3 one edge later. Change data0 to 16'h4567 → val = 4,5,6,7 next edge. Drop req0 → IDLE, val = 0,0,0,0.
- Dwell-gated preemption: req0 owning; assert req1 (data1 = 16'hEEEE) 2 cycles after grant → gnt1 stays 0 until dwell_done. gnt0→0 and gnt1→1 on the edge after dwell_done (8 cycles after grant0). val = E,E,E,E at that edge.
- Priority and handover: req1 owns while req0 is held high → no switch for 50 cycles. Drop req1 → gnt0 = 1 on the next edge, no IDLE cycle, val = data0.
- Simultaneous requests in IDLE: req0 = req1 = 1 on the same edge → gnt1 = 1. With SEG_ARB_ROUND_ROBIN_EN, repeat after requester 1 owned last → gnt0 = 1, and requester 1 is preempted by req0 after 8 cycles.
- Async reset mid-ownership: assert rst between clock edges while gnt1 = 1 → gnt1, dwell_done and val clear immediately without a clock edge. After release, with req1 still high, gnt1 re-asserts one edge later.

Source files
------------

// File: rtl/seg_arb_pkg.sv
// Shared types and helpers for the seven-segment display arbiter:
// FSM state encoding, default idle word and word-to-nibble split.
package seg_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   localparam logic [15:0] IDLE_VAL_DEFAULT = 16'h0000;

   typedef struct packed {
      logic [3:0] v3;
      logic [3:0] v2;
      logic [3:0] v1;
      logic [3:0] v0;
   } nibbles_t;

   function automatic nibbles_t split_word(input logic [15:0] i_word);
      nibbles_t w_n;
      w_n.v3 = i_word[15:12];
      w_n.v2 = i_word[11:8];
      w_n.v1 = i_word[7:4];
      w_n.v0 = i_word[3:0];
      return w_n;
   endfunction

endpackage

// File: rtl/seg_dwell_timer.sv
// Saturating dwell counter: cleared on ownership entry, o_done registers
// high on the edge where the count reaches HOLD_CYCLES-1.
module seg_dwell_timer #(
   parameter int HOLD_CYCLES = 1000000,
   parameter int CNT_W       = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   output logic o_done
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_done;

   assign w_cnt_nxt = (r_cnt == LAST) ? r_cnt : r_cnt + CNT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else if (i_clr) begin
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_done <= (w_cnt_nxt == LAST);
      end
   end

   assign o_done = r_done;

endmodule

// File: rtl/seg_display_arbiter.sv
// Two-source arbiter for the quad seven-segment display with minimum dwell.
// Define SEG_ARB_ROUND_ROBIN_EN for mutual preemption and alternating ties.
module seg_display_arbiter
   import seg_arb_pkg::*;
#(
   parameter int          HOLD_CYCLES = 1000000,
   parameter int          CNT_W       = 20,
   parameter logic [15:0] IDLE_VAL    = IDLE_VAL_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic [15:0] data0,
   input  logic        req1,
   input  logic [15:0] data1,
   output logic        gnt0,
   output logic        gnt1,
   output logic [3:0]  val3,
   output logic [3:0]  val2,
   output logic [3:0]  val1,
   output logic [3:0]  val0,
   output logic        dwell_done
);

   arb_state_t  r_state;
   arb_state_t  w_next;
   logic        r_gnt0;
   logic        r_gnt1;
   nibbles_t    r_val;
   logic [15:0] w_val_nxt;
   logic        w_done;
   logic        w_clr;

`ifdef SEG_ARB_ROUND_ROBIN_EN
   // 1 when requester 1 was the most recent owner; reset favours requester 1.
   logic r_last1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 r_last1 <= 1'b0;
      else if (w_next == OWN0) r_last1 <= 1'b0;
      else if (w_next == OWN1) r_last1 <= 1'b1;
   end
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
`ifdef SEG_ARB_ROUND_ROBIN_EN
            if (req0 && req1) w_next = r_last1 ? OWN0 : OWN1;
            else if (req1)    w_next = OWN1;
            else if (req0)    w_next = OWN0;
`else
            if (req1)         w_next = OWN1;
            else if (req0)    w_next = OWN0;
`endif
         end
         OWN0: begin
            if (!req0)                w_next = req1 ? OWN1 : IDLE;
            else if (req1 && w_done)  w_next = OWN1;
         end
         OWN1: begin
            if (!req1)                w_next = req0 ? OWN0 : IDLE;
`ifdef SEG_ARB_ROUND_ROBIN_EN
            else if (req0 && w_done)  w_next = OWN0;
`endif
         end
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_val_nxt = IDLE_VAL;
      case (w_next)
         OWN0:    w_val_nxt = data0;
         OWN1:    w_val_nxt = data1;
         default: w_val_nxt = IDLE_VAL;
      endcase
   end

   // Restart the dwell on every ownership change and keep it cleared while idle.
   assign w_clr = (w_next != r_state) || (w_next == IDLE);

   seg_dwell_timer #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .CNT_W       (CNT_W)
   ) u_dwell (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_clr),
      .o_done (w_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_gnt0  <= 1'b0;
         r_gnt1  <= 1'b0;
         r_val   <= split_word(IDLE_VAL);
      end else begin
         r_state <= w_next;
         r_gnt0  <= (w_next == OWN0);
         r_gnt1  <= (w_next == OWN1);
         r_val   <= split_word(w_val_nxt);
      end
   end

   assign gnt0       = r_gnt0;
   assign gnt1       = r_gnt1;
   assign val3       = r_val.v3;
   assign val2       = r_val.v2;
   assign val1       = r_val.v1;
   assign val0       = r_val.v0;
   assign dwell_done = w_done;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter (HOLD_CYCLES = 8, default build).
module tb_seg_display_arbiter;

   logic        clk;
   logic        rst;
   logic        req0;
   logic [15:0] data0;
   logic        req1;
   logic [15:0] data1;
   logic        gnt0;
   logic        gnt1;
   logic [3:0]  val3;
   logic [3:0]  val2;
   logic [3:0]  val1;
   logic [3:0]  val0;
   logic        dwell_done;

   int checks = 0;
   int errors = 0;

   logic [18:0] sb[$];

   seg_display_arbiter #(
      .HOLD_CYCLES (8),
      .CNT_W       (4),
      .IDLE_VAL    (16'h0000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req0       (req0),
      .data0      (data0),
      .req1       (req1),
      .data1      (data1),
      .gnt0       (gnt0),
      .gnt1       (gnt1),
      .val3       (val3),
      .val2       (val2),
      .val1       (val1),
      .val0       (val0),
      .dwell_done (dwell_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [18:0] observe();
      return {gnt0, gnt1, dwell_done, val3, val2, val1, val0};
   endfunction

   task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed g0/g1/done/val=%h expected %h", tag, obs, exp);
      end
   endtask

   // Push the expectation for the coming edge, then compare just after it.
   task automatic expect_edge(input string tag, input logic g0, input logic g1,
                              input logic dd, input logic [15:0] v);
      logic [18:0] exp;
      sb.push_back({g0, g1, dd, v});
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      check(tag, observe(), exp);
   endtask

   initial begin
      rst   = 1'b1;
      req0  = 1'b0;
      data0 = 16'h0000;
      req1  = 1'b0;
      data1 = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", observe(), 19'h0);
      #4 rst = 1'b0;

      for (int k = 0; k < 3; k++) expect_edge("idle_hold", 1'b0, 1'b0, 1'b0, 16'h0000);

      req0 = 1'b1; data0 = 16'h0123;
      expect_edge("grant0", 1'b1, 1'b0, 1'b0, 16'h0123);
      data0 = 16'h4567;
      expect_edge("data0_follow", 1'b1, 1'b0, 1'b0, 16'h4567);
      req0 = 1'b0;
      expect_edge("release_idle", 1'b0, 1'b0, 1'b0, 16'h0000);

      req0 = 1'b1; data0 = 16'h0123;
      expect_edge("grant0_dwell", 1'b1, 1'b0, 1'b0, 16'h0123);
      for (int k = 1; k <= 7; k++) begin
         expect_edge("dwell_wait", 1'b1, 1'b0, (k == 7), 16'h0123);
         if (k == 2) begin
            req1 = 1'b1; data1 = 16'hEEEE;
         end
      end
      expect_edge("preempt1", 1'b0, 1'b1, 1'b0, 16'hEEEE);

      data0 = 16'h0ABC;
      for (int k = 1; k <= 50; k++)
         expect_edge("own1_priority", 1'b0, 1'b1, (k >= 7), 16'hEEEE);
      req1 = 1'b0;
      expect_edge("handover0", 1'b1, 1'b0, 1'b0, 16'h0ABC);
      req0 = 1'b0;
      expect_edge("back_idle", 1'b0, 1'b0, 1'b0, 16'h0000);

      req0 = 1'b1; data0 = 16'h1111; req1 = 1'b1; data1 = 16'h2222;
      expect_edge("simul_req", 1'b0, 1'b1, 1'b0, 16'h2222);
      data1 = 16'h3333;
      expect_edge("data1_follow", 1'b0, 1'b1, 1'b0, 16'h3333);

      #2 rst = 1'b1;
      #1 check("async_rst", observe(), 19'h0);
      #2 rst = 1'b0;
      req0 = 1'b0;
      expect_edge("regrant1", 1'b0, 1'b1, 1'b0, 16'h3333);
      expect_edge("regrant1_hold", 1'b0, 1'b1, 1'b0, 16'h3333);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
